// File: rtl/alu.sv
// Purpose: 32-bit ALU with flags, plus optional MULT/DIV writing the HI/LO register pair.
// Latency: Y and carryFlags are combinational (0 cycles); HI/LO update 1 Clk after MULT/DIV is presented.
// Backpressure: none; a new operation is accepted every cycle and back-to-back MULT/DIV overwrite HI/LO.
//
// Ports:
//   Clk        - clock; HI/LO update on its rising edge
//   reset      - synchronous active-high clear of HI/LO (Y/carryFlags unaffected)
//   A, B       - operands; A[4:0] is the shift amount, B is the shifted value
//   operation  - 4-bit opcode
//   sign       - sign[0]=1 selects signed arithmetic/compares; sign[1] is unused
//   cmpsignal  - condition for CMP
//   Y          - combinational result
//   HI, LO     - registered product high/low or remainder/quotient
//   carryFlags - {N,Z,C,V}
// Build option: define ALU_MULDIV_EN to include the multiplier and divider.
// Without it, MULT/DIV produce Y=0 and HI/LO only ever hold or clear on reset.

module alu (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  operation,
    input  logic [1:0]  sign,
    input  logic [2:0]  cmpsignal,
    output logic [31:0] Y,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [3:0]  carryFlags
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_PASSA = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;
    localparam logic [3:0] OP_CMP   = 4'b1111;

    // sign[1] carries no meaning for this block
    logic unused_sign_hi;
    assign unused_sign_hi = sign[1];

    logic        signed_op;
    logic [32:0] sum33;
    logic [32:0] diff33;
    logic        ovf_add;
    logic        ovf_sub;
    logic        lt;
    logic        eq;
    logic        cond;
    logic        c_flag;
    logic        v_flag;

    assign signed_op = sign[0];

    always_comb begin
        sum33   = {1'b0, A} + {1'b0, B};
        // A + ~B + 1: bit 32 is the inverted borrow (1 when A >= B unsigned)
        diff33  = {1'b0, A} + {1'b0, ~B} + 33'd1;
        ovf_add = (A[31] == B[31]) && (sum33[31] != A[31]);
        ovf_sub = (A[31] != B[31]) && (diff33[31] != A[31]);
        lt      = signed_op ? ($signed(A) < $signed(B)) : (A < B);
        eq      = (A == B);
    end

    always_comb begin
        cond = 1'b0;
        case (cmpsignal)
            3'b000: cond = eq;
            3'b001: cond = !eq;
            3'b010: cond = lt;
            3'b011: cond = lt || eq;
            3'b100: cond = !(lt || eq);
            3'b101: cond = !lt;
            3'b110: cond = A[31];   // always a signed test of A
            3'b111: cond = !A[31];
            default: cond = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // One 64x64 multiply serves both modes: operands are sign- or zero-extended
    // to 64 bits, and the low 64 bits of the product are correct either way.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    always_comb begin
        ext_a = {{32{signed_op & A[31]}}, A};
        ext_b = {{32{signed_op & B[31]}}, B};
        prod  = ext_a * ext_b;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward zero
    // and the remainder follows the dividend. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    always_comb begin
        neg_a    = signed_op & A[31];
        neg_b    = signed_op & B[31];
        mag_a    = neg_a ? (32'd0 - A) : A;
        mag_b    = neg_b ? (32'd0 - B) : B;
        div_zero = (B == 32'd0);
        uq       = 32'd0;
        ur       = 32'd0;
        if (!div_zero) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quot = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem  = neg_a ? (32'd0 - ur) : ur;
        if (div_zero) begin
            quot = 32'hFFFF_FFFF;
            rem  = A;
        end
    end
`endif

    always_comb begin
        Y      = 32'd0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (operation)
            OP_ADD: begin
                Y      = sum33[31:0];
                c_flag = sum33[32];
                v_flag = signed_op & ovf_add;
            end
            OP_SUB: begin
                Y      = diff33[31:0];
                c_flag = diff33[32];
                v_flag = signed_op & ovf_sub;
            end
            OP_AND:   Y = A & B;
            OP_OR:    Y = A | B;
            OP_XOR:   Y = A ^ B;
            OP_NOR:   Y = ~(A | B);
            OP_SLL:   Y = B << A[4:0];
            OP_SRL:   Y = B >> A[4:0];
            OP_SRA:   Y = $signed(B) >>> A[4:0];
            OP_SLT: begin
                Y      = {31'd0, lt};
                c_flag = diff33[32];
            end
            OP_LUI:   Y = {B[15:0], 16'h0000};
`ifdef ALU_MULDIV_EN
            OP_MULT:  Y = prod[31:0];
            OP_DIV: begin
                Y      = quot;
                v_flag = div_zero;
            end
`endif
            OP_PASSA: Y = A;
            OP_PASSB: Y = B;
            OP_CMP: begin
                Y      = {31'd0, cond};
                c_flag = diff33[32];
            end
            default:  Y = 32'd0;
        endcase
        carryFlags = {Y[31], (Y == 32'd0), c_flag, v_flag};
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end
`ifdef ALU_MULDIV_EN
        else if (operation == OP_MULT) begin
            HI <= prod[63:32];
            LO <= prod[31:0];
        end else if (operation == OP_DIV) begin
            HI <= rem;
            LO <= quot;
        end
`endif
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: a vector table for the combinational operations,
// followed by clocked sequences for HI/LO loading, holding and reset priority.
module tb_alu;

    logic        Clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  operation;
    logic [1:0]  sign;
    logic [2:0]  cmpsignal;
    logic [31:0] Y;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [3:0]  carryFlags;

    int n_checks = 0;
    int n_errors = 0;

    alu dut (
        .Clk        (Clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .operation  (operation),
        .sign       (sign),
        .cmpsignal  (cmpsignal),
        .Y          (Y),
        .HI         (HI),
        .LO         (LO),
        .carryFlags (carryFlags)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  s;
        logic [2:0]  c;
        logic [31:0] y;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, input logic [2:0] c);
        operation = op;
        A         = a;
        B         = b;
        sign      = s;
        cmpsignal = c;
    endtask

    // drive at posedge+1, check combinational outputs at posedge+2
    task automatic comb_check(input string name, input logic [31:0] ey, input logic [3:0] ef);
        #1;
        check({name, ".Y"}, Y, ey);
        check({name, ".flags"}, {28'd0, carryFlags}, {28'd0, ef});
    endtask

    // advance one edge and check the registered pair
    task automatic edge_check(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        @(posedge Clk);
        #1;
        check({name, ".HI"}, HI, ehi);
        check({name, ".LO"}, LO, elo);
    endtask

    initial begin
        //               op       A             B             s      cmp     Y             NZCV
        vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 2'b01, 3'b000, 32'h80000000, 4'b1001};
        vecs[1]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 2'b00, 3'b000, 32'h00000000, 4'b0110};
        vecs[2]  = '{4'b0001, 32'h00000005, 32'h00000005, 2'b01, 3'b000, 32'h00000000, 4'b0110};
        vecs[3]  = '{4'b0001, 32'h00000003, 32'h00000005, 2'b00, 3'b000, 32'hFFFFFFFE, 4'b1000};
        vecs[4]  = '{4'b0001, 32'h80000000, 32'h00000001, 2'b01, 3'b000, 32'h7FFFFFFF, 4'b0011};
        vecs[5]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 3'b000, 32'hF000F000, 4'b1000};
        vecs[6]  = '{4'b0011, 32'h0F0F0000, 32'h000000F0, 2'b00, 3'b000, 32'h0F0F00F0, 4'b0000};
        vecs[7]  = '{4'b0100, 32'hAAAAAAAA, 32'hAAAAAAAA, 2'b00, 3'b000, 32'h00000000, 4'b0100};
        vecs[8]  = '{4'b0101, 32'h00000000, 32'h00000000, 2'b00, 3'b000, 32'hFFFFFFFF, 4'b1000};
        vecs[9]  = '{4'b0110, 32'h00000024, 32'h00000003, 2'b00, 3'b000, 32'h00000030, 4'b0000};
        vecs[10] = '{4'b0111, 32'h00000004, 32'h80000000, 2'b00, 3'b000, 32'h08000000, 4'b0000};
        vecs[11] = '{4'b1000, 32'h00000004, 32'h80000000, 2'b00, 3'b000, 32'hF8000000, 4'b1000};
        vecs[12] = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 2'b01, 3'b000, 32'h00000001, 4'b0010};
        vecs[13] = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 2'b00, 3'b000, 32'h00000000, 4'b0110};
        vecs[14] = '{4'b1010, 32'h00000000, 32'hABCD1234, 2'b00, 3'b000, 32'h12340000, 4'b0000};
        vecs[15] = '{4'b1101, 32'h80000000, 32'h00000007, 2'b00, 3'b000, 32'h80000000, 4'b1000};
        vecs[16] = '{4'b1110, 32'h12345678, 32'h00000000, 2'b00, 3'b000, 32'h00000000, 4'b0100};
        vecs[17] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 2'b01, 3'b010, 32'h00000001, 4'b0010};
        vecs[18] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 2'b00, 3'b010, 32'h00000000, 4'b0110};
        vecs[19] = '{4'b1111, 32'h00000005, 32'h00000005, 2'b00, 3'b000, 32'h00000001, 4'b0010};
        vecs[20] = '{4'b1111, 32'h00000005, 32'h00000005, 2'b00, 3'b001, 32'h00000000, 4'b0110};
        vecs[21] = '{4'b1111, 32'h00000003, 32'h00000005, 2'b00, 3'b011, 32'h00000001, 4'b0000};
        vecs[22] = '{4'b1111, 32'h00000003, 32'h00000005, 2'b01, 3'b100, 32'h00000000, 4'b0100};
        vecs[23] = '{4'b1111, 32'h00000005, 32'h00000003, 2'b01, 3'b101, 32'h00000001, 4'b0010};
        vecs[24] = '{4'b1111, 32'h80000000, 32'h00000000, 2'b00, 3'b110, 32'h00000001, 4'b0010};
        vecs[25] = '{4'b1111, 32'h80000000, 32'h00000000, 2'b00, 3'b111, 32'h00000000, 4'b0110};
        vecs[26] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 2'b10, 3'b000, 32'h80000000, 4'b1000};

        reset = 1'b1;
        drive(4'b0000, 32'd0, 32'd0, 2'b00, 3'b000);
        edge_check("reset", 32'd0, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge Clk);
            #1;
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
            comb_check($sformatf("vec%0d", i), vecs[i].y, vecs[i].f);
        end
        // none of the table ops touch HI/LO
        edge_check("hold_after_table", 32'd0, 32'd0);

`ifdef ALU_MULDIV_EN
        // signed MULT -3 * 7 = -21
        drive(4'b1011, 32'hFFFFFFFD, 32'h00000007, 2'b01, 3'b000);
        comb_check("mult_s", 32'hFFFFFFEB, 4'b1000);
        edge_check("mult_s", 32'hFFFFFFFF, 32'hFFFFFFEB);

        // non-mul/div op holds HI/LO
        drive(4'b1101, 32'h00000055, 32'h00000000, 2'b01, 3'b000);
        edge_check("hold_passa", 32'hFFFFFFFF, 32'hFFFFFFEB);

        // signed DIV -7 / 2 = -3 rem -1
        drive(4'b1100, 32'hFFFFFFF9, 32'h00000002, 2'b01, 3'b000);
        comb_check("div_s", 32'hFFFFFFFD, 4'b1000);
        edge_check("div_s", 32'hFFFFFFFF, 32'hFFFFFFFD);

        // unsigned MULT 0xFFFFFFFF * 2, back-to-back with the DIV above
        drive(4'b1011, 32'hFFFFFFFF, 32'h00000002, 2'b00, 3'b000);
        comb_check("mult_u", 32'hFFFFFFFE, 4'b1000);
        edge_check("mult_u", 32'h00000001, 32'hFFFFFFFE);

        // unsigned DIV 0xFFFFFFF9 / 2
        drive(4'b1100, 32'hFFFFFFF9, 32'h00000002, 2'b00, 3'b000);
        comb_check("div_u", 32'h7FFFFFFC, 4'b0000);
        edge_check("div_u", 32'h00000001, 32'h7FFFFFFC);

        // signed overflow divide
        drive(4'b1100, 32'h80000000, 32'hFFFFFFFF, 2'b01, 3'b000);
        comb_check("div_ovf", 32'h80000000, 4'b1000);
        edge_check("div_ovf", 32'h00000000, 32'h80000000);

        // divide by zero
        drive(4'b1100, 32'h00000009, 32'h00000000, 2'b00, 3'b000);
        comb_check("div_zero", 32'hFFFFFFFF, 4'b1001);
        edge_check("div_zero", 32'h00000009, 32'hFFFFFFFF);

        // reset wins over MULT; Y still reflects the MULT
        reset = 1'b1;
        drive(4'b1011, 32'hFFFFFFFD, 32'h00000007, 2'b01, 3'b000);
        comb_check("reset_mult", 32'hFFFFFFEB, 4'b1000);
        edge_check("reset_mult", 32'd0, 32'd0);
        reset = 1'b0;
`else
        // MULT/DIV are inert: Y=0, flags Z only, HI/LO unchanged
        drive(4'b1011, 32'hFFFFFFFD, 32'h00000007, 2'b01, 3'b000);
        comb_check("mult_off", 32'd0, 4'b0100);
        edge_check("mult_off", 32'd0, 32'd0);

        drive(4'b1100, 32'h00000009, 32'h00000000, 2'b01, 3'b000);
        comb_check("div_off", 32'd0, 4'b0100);
        edge_check("div_off", 32'd0, 32'd0);

        reset = 1'b1;
        drive(4'b0000, 32'h7FFFFFFF, 32'h00000001, 2'b01, 3'b000);
        comb_check("reset_add", 32'h80000000, 4'b1001);
        edge_check("reset_add", 32'd0, 32'd0);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
